// File: rtl/fifo_spram_rd_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fifo_spram_rd_prefetch
// Description : Read-side engine for a single-port-RAM FIFO that shares its
//               clock domain with the writer. It follows the writer's pointer
//               and requests RAM reads through a shared port arbiter. A small
//               output buffer hides the 1-cycle RAM read latency and feeds a
//               valid/ready stream with no bubbles. The read pointer is
//               published so that the writer can compute free space.
// Ports       : clk, rst_n (async, active-low), flush (sync drop + resync)
//               wr_ptr / rd_ptr      : ADDR_WIDTH+1 pointers, MSB is the wrap bit
//               rd_req/rd_addr/rd_gnt: RAM read port, arbitrated
//               rd_data              : RAM data, one cycle after a grant
//               out_data/out_valid/out_ready : downstream stream
//               obuf_count           : words held in the output buffer
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_spram_rd_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int OBUF_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [ADDR_WIDTH:0]             wr_ptr,
    output logic [ADDR_WIDTH:0]             rd_ptr,
    output logic                            rd_req,
    output logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic                            rd_gnt,
    input  logic [DATA_WIDTH-1:0]           rd_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(OBUF_DEPTH+1)-1:0] obuf_count
);

    localparam int c_CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam int c_IDX_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int c_PTR_W = ADDR_WIDTH + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(OBUF_DEPTH - 1);

    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_inflight;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_IDX_W-1:0]    r_head;
    logic [c_IDX_W-1:0]    r_tail;
    logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];

    logic                  w_pop;
    logic                  w_ram_avail;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_space;
    logic                  w_req;
    logic                  w_issue;
    logic                  w_capture;
    logic [c_CNT_W-1:0]    w_count_nxt;

    // Circular index increment. This also works when OBUF_DEPTH is not a power of two.
    function automatic logic [c_IDX_W-1:0] f_next(input logic [c_IDX_W-1:0] idx);
        if (idx == c_LAST_IDX) begin
            f_next = '0;
        end else begin
            f_next = idx + c_IDX_W'(1);
        end
    endfunction

    // A flush drops everything, so a pop during flush has no effect.
    assign w_pop       = (r_count != '0) & out_ready & ~flush;
    // Equal pointers mean empty. Pointers that differ only in the wrap bit mean full.
    assign w_ram_avail = (wr_ptr != r_rd_ptr);

    // This is the occupancy the buffer will have once the in-flight word lands
    // and this cycle's pop leaves. A read is issued only when a slot is still
    // free after that. Buffer space is therefore reserved at issue time, and
    // the capture never needs a stall. The comb path from out_ready to rd_req
    // is what gives back-to-back throughput with two entries.
    assign w_occ   = {1'b0, r_count} + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_space = (w_occ < c_OCC_W'(OBUF_DEPTH));

    assign w_req     = w_ram_avail & ~flush & w_space;
    assign w_issue   = w_req & rd_gnt;
    assign w_capture = r_inflight & ~flush;

    assign w_count_nxt = r_count + c_CNT_W'(w_capture) - c_CNT_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Resync to the writer. Any data returning this cycle is discarded.
            r_rd_ptr   <= wr_ptr;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_inflight <= w_issue;
            if (w_capture) begin
                r_mem[r_tail] <= rd_data;
                r_tail        <= f_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            r_count <= w_count_nxt;
        end
    end

    assign rd_ptr     = r_rd_ptr;
    assign rd_req     = w_req;
    assign rd_addr    = r_rd_ptr[ADDR_WIDTH-1:0];
    assign out_data   = r_mem[r_head];
    assign out_valid  = (r_count != '0);
    assign obuf_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_spram_rd_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_spram_rd_prefetch
// Description : Self-checking bench for fifo_spram_rd_prefetch. A RAM array
//               and the writer pointer are driven from here. A queue-based
//               model of the output stream supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_spram_rd_prefetch;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int OBD = 2;
    localparam int CW  = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          flush     = 1'b0;
    logic [AW:0]   wr_ptr    = '0;
    logic [AW:0]   rd_ptr;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt    = 1'b0;
    logic [DW-1:0] rd_data   = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] obuf_count;

    fifo_spram_rd_prefetch #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEP),
        .ADDR_WIDTH (AW),
        .OBUF_DEPTH (OBD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .obuf_count (obuf_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // RAM contents and the reference model state
    logic [DW-1:0] ram [DEP];
    logic [AW:0]   m_rd_ptr   = '0;
    logic [DW-1:0] m_q [$];
    logic          m_inflight = 1'b0;
    logic [DW-1:0] m_inf_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_words(input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            ram[wr_ptr[AW-1:0]] = base + DW'(k);
            wr_ptr = wr_ptr + 1'b1;
        end
    endtask

    // Call at posedge+1 with the inputs already set. The task checks at
    // posedge+2, steps the model, waits for the edge, and then returns the
    // RAM read data. Without a grant, rd_data carries random garbage.
    task automatic cycle();
        logic          m_pop;
        logic          m_req;
        int            occ;
        logic          ram_hit;
        logic [DW-1:0] ram_word;
        #1;
        m_pop = (m_q.size() > 0) && out_ready && !flush;
        occ   = m_q.size() + int'(m_inflight) - int'(m_pop);
        m_req = (wr_ptr != m_rd_ptr) && !flush && (occ < OBD);
        check("rd_req",     32'(rd_req),     32'(m_req));
        check("rd_addr",    32'(rd_addr),    32'(m_rd_ptr[AW-1:0]));
        check("rd_ptr",     32'(rd_ptr),     32'(m_rd_ptr));
        check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
        check("obuf_count", 32'(obuf_count), 32'(m_q.size()));
        if (m_q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(m_q[0]));
        end
        ram_hit  = rd_req && rd_gnt;
        ram_word = ram[rd_addr];
        if (flush) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_rd_ptr   = wr_ptr;
        end else begin
            if (m_pop) begin
                void'(m_q.pop_front());
            end
            if (m_inflight) begin
                m_q.push_back(m_inf_data);
            end
            if (m_req && rd_gnt) begin
                m_inf_data = ram[m_rd_ptr[AW-1:0]];
                m_rd_ptr   = m_rd_ptr + 1'b1;
                m_inflight = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rd_data = ram_hit ? ram_word : DW'($urandom);
    endtask

    // Assert reset between edges and check that outputs clear with no clock
    // edge in between. The writer is reset along with the reader.
    task automatic do_reset();
        rst_n     = 1'b0;
        wr_ptr    = '0;
        flush     = 1'b0;
        rd_gnt    = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_rd_ptr",     32'(rd_ptr),     32'd0);
        check("rst_rd_req",     32'(rd_req),     32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_obuf_count", 32'(obuf_count), 32'd0);
        m_rd_ptr   = '0;
        m_q.delete();
        m_inflight = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rd_data = DW'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        #1;

        // 1: reset state, then first-word latency
        do_reset();
        cycle();
        write_words(1, 8'h5A);
        rd_gnt = 1'b1;
        cycle();
        cycle();
        check("t1_valid_2cyc", 32'(out_valid), 32'd1);
        check("t1_rd_ptr",     32'(rd_ptr),    32'd1);
        check("t1_data",       32'(out_data),  32'h5A);
        out_ready = 1'b1;
        repeat (2) cycle();

        // 2: eight words stream back-to-back
        do_reset();
        write_words(8, 8'hA0);
        rd_gnt    = 1'b1;
        out_ready = 1'b1;
        repeat (12) cycle();
        check("t2_rd_ptr", 32'(rd_ptr), 32'd8);
        check("t2_rd_req", 32'(rd_req), 32'd0);

        // 3: back-pressure stops reads once the buffer is full
        do_reset();
        write_words(5, 8'h50);
        rd_gnt = 1'b1;
        repeat (6) cycle();
        check("t3_count", 32'(obuf_count), 32'd2);
        check("t3_rd_ptr", 32'(rd_ptr),    32'd2);
        check("t3_rd_req", 32'(rd_req),    32'd0);
        out_ready = 1'b1;
        repeat (8) cycle();
        check("t3_rd_ptr_end", 32'(rd_ptr), 32'd5);

        // 4: grant toggling holds the request stable
        do_reset();
        write_words(4, 8'hC0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd_gnt = pat[i][0];
            cycle();
        end
        check("t4_rd_ptr", 32'(rd_ptr), 32'd4);

        // 5: pointer wrap, and a full RAM counted as available
        do_reset();
        write_words(15, 8'h10);
        rd_gnt    = 1'b1;
        out_ready = 1'b1;
        repeat (20) cycle();
        check("t5_rd_ptr15", 32'(rd_ptr), 32'd15);
        write_words(2, 8'hE0);
        repeat (6) cycle();
        check("t5_rd_ptr17", 32'(rd_ptr), 32'd17);
        check("t5_empty_req", 32'(rd_req), 32'd0);
        do_reset();
        write_words(16, 8'h30);
        rd_gnt = 1'b1;
        #1;
        check("t5_full_req", 32'(rd_req), 32'd1);
        for (int i = 0; i < 30; i++) begin
            out_ready = 1'($urandom);
            cycle();
        end

        // 6: flush with a read in flight, flush with a full buffer, async reset mid-stream
        do_reset();
        write_words(6, 8'h70);
        rd_gnt = 1'b1;
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t6_valid",  32'(out_valid),  32'd0);
        check("t6_count",  32'(obuf_count), 32'd0);
        check("t6_rd_ptr", 32'(rd_ptr),     32'(wr_ptr));
        repeat (2) cycle();
        write_words(4, 8'h90);
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t6b_count", 32'(obuf_count), 32'd0);
        out_ready = 1'b1;
        write_words(3, 8'hB0);
        repeat (2) cycle();
        do_reset();
        repeat (3) cycle();

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int used;
            int free;
            rd_gnt    = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            used      = int'(5'(wr_ptr - m_rd_ptr));
            free      = DEP - used;
            if (free > 0) begin
                write_words($urandom_range(0, (free > 3) ? 3 : free), DW'($urandom));
            end
            cycle();
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
